// File: rtl/simon_seq_ctrl.sv
// -----------------------------------------------------------------------------
// simon_seq_ctrl
//
// Sequencing controller between a 32-bit valid/ready stream and a Simon
// 128/128 core. It collects eight input words (four plaintext words, then four
// key words, each LSW first) and presents them to the core. It pulses the
// core reset for one cycle and counts CORE_LAT cycles of core operation. It
// then captures the 128-bit ciphertext and streams it out as four 32-bit words,
// LSW first.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   s_valid      input word valid
//   s_ready      controller accepts an input word (registered)
//   s_data       input word
//   m_valid      output ciphertext word valid (registered)
//   m_ready      downstream accepts an output word
//   m_data       output ciphertext word (mux of registers)
//   pt_o         plaintext to the core
//   k0_o         initial key to the core
//   core_rst_n   active-low reset to the core (registered)
//   ct_i         ciphertext from the core
//   busy         high in every state except LOAD (registered)
// -----------------------------------------------------------------------------
module simon_seq_ctrl #(
  parameter int CORE_LAT = 68
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [31:0]  m_data,
  output logic [127:0] pt_o,
  output logic [127:0] k0_o,
  output logic         core_rst_n,
  input  logic [127:0] ct_i,
  output logic         busy
);

  localparam int CNT_W = $clog2(CORE_LAT + 1);
  // The capture edge is the one on which the counter steps to CORE_LAT.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CORE_LAT - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_CORE_RST,
    S_RUN,
    S_UNLOAD
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [2:0]         r_in_idx;
  logic [1:0]         r_out_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0][31:0]   r_pt;
  logic [3:0][31:0]   r_k0;
  logic [3:0][31:0]   r_cap;
  logic               r_s_ready;
  logic               r_m_valid;
  logic               r_core_rst_n;
  logic               r_busy;

  logic               w_s_xfer;
  logic               w_m_xfer;
  logic               w_capture;

  assign w_s_xfer  = s_valid && r_s_ready;
  assign w_m_xfer  = r_m_valid && m_ready;
  assign w_capture = (r_state == S_RUN) && r_core_rst_n && (r_cnt == LAST_CNT);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its sources, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: w_next is defaulted before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_LOAD:     if (w_s_xfer && (r_in_idx == 3'd7)) w_next = S_CORE_RST;
      S_CORE_RST: w_next = S_RUN;
      S_RUN:      if (w_capture) w_next = S_UNLOAD;
      S_UNLOAD:   if (w_m_xfer && (r_out_idx == 2'd3)) w_next = S_LOAD;
      default:    w_next = S_LOAD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  // Handshake and core-control outputs are decoded from the next state so they
  // change on the same edge as the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_idx     <= '0;
      r_out_idx    <= '0;
      r_cnt        <= '0;
      r_pt         <= '0;
      r_k0         <= '0;
      r_cap        <= '0;
      r_s_ready    <= 1'b0;
      r_m_valid    <= 1'b0;
      r_core_rst_n <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_s_ready    <= (w_next == S_LOAD);
      r_m_valid    <= (w_next == S_UNLOAD);
      r_core_rst_n <= (w_next == S_RUN);
      r_busy       <= (w_next != S_LOAD);

      // Index bit 2 selects plaintext (words 0..3) or key (words 4..7); the
      // 3-bit index wraps to 0 on the 8th transfer.
      if (w_s_xfer) begin
        if (r_in_idx[2]) begin
          r_k0[r_in_idx[1:0]] <= s_data;
        end else begin
          r_pt[r_in_idx[1:0]] <= s_data;
        end
        r_in_idx <= r_in_idx + 3'd1;
      end

      // Held at zero outside RUN, so it is already clear on entry to RUN.
      if ((r_state == S_RUN) && r_core_rst_n) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end

      // ct_i is only looked at on the capture edge.
      if (w_capture) begin
        r_cap <= ct_i;
      end

      // The 2-bit output index wraps to 0 on the 4th transfer.
      if (w_m_xfer) begin
        r_out_idx <= r_out_idx + 2'd1;
      end
    end
  end

  assign s_ready    = r_s_ready;
  assign m_valid    = r_m_valid;
  assign m_data     = r_cap[r_out_idx];
  assign pt_o       = r_pt;
  assign k0_o       = r_k0;
  assign core_rst_n = r_core_rst_n;
  assign busy       = r_busy;

endmodule
